// File: rtl/reg_share_arbiter.sv
// Two-requester arbiter that owns the load of one shared WIDTH-bit register: grant, load, ack, then hold stable.
// Optional build macro ARB_FIXED_PRIORITY_EN makes requester 0 win every tie instead of round robin.

module reg_share_arbiter #(
   parameter int WIDTH = 4,
   parameter int HOLD  = 2
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [1:0]       i_req,
   input  logic [WIDTH-1:0] i_data0,
   input  logic [WIDTH-1:0] i_data1,
   output logic [1:0]       o_gnt,
   output logic [1:0]       o_ack,
   output logic [WIDTH-1:0] o_dataout,
   output logic             o_valid,
   output logic             o_owner
);

   localparam logic [3:0] HOLD_CNT = 4'(HOLD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_gnt;
   logic [1:0]       w_gnt_nxt;
   logic [1:0]       r_ack;
   logic [1:0]       w_ack_nxt;
   logic [WIDTH-1:0] r_dataout;
   logic [WIDTH-1:0] w_dataout_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_owner;
   logic             w_owner_nxt;
   logic             r_win;
   logic             w_win_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic             w_pick;
`ifndef ARB_FIXED_PRIORITY_EN
   logic             r_last;
   logic             w_last_nxt;
`endif

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // Winner selection for the current request pattern
   always_comb begin
      w_pick = 1'b0;
      case (i_req)
         2'b01:   w_pick = 1'b0;
         2'b10:   w_pick = 1'b1;
         2'b11: begin
`ifdef ARB_FIXED_PRIORITY_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last;
`endif
         end
         default: w_pick = 1'b0;
      endcase
   end

   // Next-state and next-output logic; every output is taken from a register
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_ack_nxt     = 2'b00;
      w_dataout_nxt = r_dataout;
      w_valid_nxt   = r_valid;
      w_owner_nxt   = r_owner;
      w_win_nxt     = r_win;
      w_cnt_nxt     = r_cnt;
`ifndef ARB_FIXED_PRIORITY_EN
      w_last_nxt    = r_last;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_req != 2'b00) begin
               w_state_nxt = S_LOAD;
               w_win_nxt   = w_pick;
               w_gnt_nxt   = onehot(w_pick);
            end else begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = 2'b00;
            end
         end
         S_LOAD: begin
            // Winner's req is not re-sampled: a dropped request still completes
            w_dataout_nxt = r_win ? i_data1 : i_data0;
            w_owner_nxt   = r_win;
            w_valid_nxt   = 1'b1;
            w_ack_nxt     = onehot(r_win);
            w_state_nxt   = S_ACK;
`ifndef ARB_FIXED_PRIORITY_EN
            w_last_nxt    = r_win;
`endif
         end
         S_ACK: begin
            w_gnt_nxt = 2'b00;
            if (HOLD_CNT != 4'd0) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = HOLD_CNT;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         S_HOLD: begin
            w_gnt_nxt = 2'b00;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 2'b00;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and output registers; reset discards any load in flight
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_gnt     <= 2'b00;
         r_ack     <= 2'b00;
         r_dataout <= '0;
         r_valid   <= 1'b0;
         r_owner   <= 1'b0;
         r_win     <= 1'b0;
         r_cnt     <= 4'd0;
`ifndef ARB_FIXED_PRIORITY_EN
         r_last    <= 1'b1;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_ack     <= w_ack_nxt;
         r_dataout <= w_dataout_nxt;
         r_valid   <= w_valid_nxt;
         r_owner   <= w_owner_nxt;
         r_win     <= w_win_nxt;
         r_cnt     <= w_cnt_nxt;
`ifndef ARB_FIXED_PRIORITY_EN
         r_last    <= w_last_nxt;
`endif
      end
   end

   assign o_gnt     = r_gnt;
   assign o_ack     = r_ack;
   assign o_dataout = r_dataout;
   assign o_valid   = r_valid;
   assign o_owner   = r_owner;

endmodule
